fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/pc_next.sv | 36 +++
 rtl/fetch_stage.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } fault_t;

    localparam logic [31:0] NOP_INST           = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int          DEFAULT_IMEM_WORDS = 8192;

endpackage

// File: rtl/pc_next.sv
// Next-PC mux (redirect / +4 / hold) plus alignment and range checks on
// both the current PC and the redirect target. Purely combinational.
module pc_next
    import fetch_pkg::*;
#(
    parameter int IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
    input  logic [31:0] pc,
    input  logic [31:0] redirect_pc,
    input  logic        sel_redirect,
    input  logic        sel_advance,
    output logic [31:0] next_pc,
    output logic        pc_bad_align,
    output logic        pc_bad_range,
    output logic        target_bad_align,
    output logic        target_bad_range
);

    // 33-bit limit so a 4 GiB memory size cannot overflow the compare.
    localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) << 2;

    assign pc_bad_align     = |pc[1:0];
    assign pc_bad_range     = {1'b0, pc} >= LIMIT;
    assign target_bad_align = |redirect_pc[1:0];
    assign target_bad_range = {1'b0, redirect_pc} >= LIMIT;

    always_comb begin
        next_pc = pc;
        if (sel_redirect) begin
            next_pc = redirect_pc;
        end else if (sel_advance) begin
            next_pc = pc + 32'd4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Single-entry instruction fetch stage with redirect flush, stall hold,
// valid/ready handoff to decode and sticky fetch-fault reporting.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_inst,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [1:0]  o_fault,
    output logic [31:0] o_fault_pc,
    output logic [31:0] o_fetch_cnt
);

    state_t      state_reg, state_next;
    fault_t      fault_reg, fault_next;
    logic [31:0] pc_reg;
    logic [31:0] inst_reg, inst_next;
    logic [31:0] opc_reg, opc_next;
    logic        valid_reg, valid_next;
    logic [31:0] fault_pc_reg, fault_pc_next;
    logic [31:0] cnt_reg, cnt_next;

    logic        sel_redirect;
    logic        sel_advance;
    logic [31:0] next_pc;
    logic        pc_bad_align;
    logic        pc_bad_range;
    logic        target_bad_align;
    logic        target_bad_range;
    logic        accept;

    pc_next #(
        .IMEM_WORDS(IMEM_WORDS)
    ) u_pc_next (
        .pc              (pc_reg),
        .redirect_pc     (i_redirect_pc),
        .sel_redirect    (sel_redirect),
        .sel_advance     (sel_advance),
        .next_pc         (next_pc),
        .pc_bad_align    (pc_bad_align),
        .pc_bad_range    (pc_bad_range),
        .target_bad_align(target_bad_align),
        .target_bad_range(target_bad_range)
    );

    assign accept = valid_reg && i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_BOOT;
            pc_reg       <= RESET_PC;
            inst_reg     <= NOP_INST;
            opc_reg      <= 32'd0;
            valid_reg    <= 1'b0;
            fault_reg    <= FAULT_NONE;
            fault_pc_reg <= 32'd0;
            cnt_reg      <= 32'd0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= next_pc;
            inst_reg     <= inst_next;
            opc_reg      <= opc_next;
            valid_reg    <= valid_next;
            fault_reg    <= fault_next;
            fault_pc_reg <= fault_pc_next;
            cnt_reg      <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        inst_next     = inst_reg;
        opc_next      = opc_reg;
        valid_next    = valid_reg;
        fault_next    = fault_reg;
        fault_pc_next = fault_pc_reg;
        // An accept always counts, even when the same edge flushes.
        cnt_next      = cnt_reg + {31'd0, accept};
        sel_redirect  = 1'b0;
        sel_advance   = 1'b0;

        case (state_reg)
            ST_BOOT: begin
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (i_redirect) begin
                    valid_next = 1'b0;
                    if (target_bad_align) begin
                        state_next    = ST_FAULT;
                        fault_next    = FAULT_MISALIGN;
                        fault_pc_next = i_redirect_pc;
                    end else begin
                        // Out-of-range targets are caught when fetched next cycle.
                        sel_redirect = 1'b1;
                    end
                end else if (!i_stall && (!valid_reg || i_ready)) begin
                    if (pc_bad_align || pc_bad_range) begin
                        state_next    = ST_FAULT;
                        fault_next    = pc_bad_align ? FAULT_MISALIGN : FAULT_RANGE;
                        fault_pc_next = pc_reg;
                        valid_next    = 1'b0;
                    end else begin
                        sel_advance = 1'b1;
                        inst_next   = i_imem_inst;
                        opc_next    = pc_reg;
                        valid_next  = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                valid_next = 1'b0;
                if (i_redirect && !target_bad_align && !target_bad_range) begin
                    state_next    = ST_RUN;
                    fault_next    = FAULT_NONE;
                    fault_pc_next = 32'd0;
                    sel_redirect  = 1'b1;
                end
            end
            default: begin
                state_next = ST_BOOT;
                valid_next = 1'b0;
            end
        endcase
    end

    assign o_imem_addr = pc_reg;
    assign o_inst      = inst_reg;
    assign o_pc        = opc_reg;
    assign o_pc4       = opc_reg + 32'd4;
    assign o_valid     = valid_reg;
    assign o_fault     = fault_reg;
    assign o_fault_pc  = fault_pc_reg;
    assign o_fetch_cnt = cnt_reg;

endmodule
